// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle RV32I control unit.
// Imported by the controller top and its memory wait timer.
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        RW_ALU_MEM = 2'b00,
        RW_PC4     = 2'b01,
        RW_IMM     = 2'b10
    } rw_sel_t;

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts unacknowledged memory-request cycles and pulses expire on the last
// allowed cycle so the controller can trap instead of waiting forever.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + ONE;
        end
    end

    assign expire = count_en && (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM: fetch/decode/exec/mem/wb sequencing with
// memory handshake, external stall and sticky illegal/timeout traps.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit SUPPORT_AUIPC = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ack,
    input  logic       stall,
    output logic       pc_write,
    output logic       ir_write,
    output logic       alu_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] rw_sel,
    output logic       branch,
    output logic       jalr_sel,
    output logic       illegal_instr,
    output logic       timeout_err,
    output logic [2:0] state_o
);

    state_t state, state_next;
    logic is_r, is_i, is_lui, is_auipc, is_lw, is_sw, is_br, is_jal, is_jalr, is_legal;
    logic wait_cycle, expire;

    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_lui   = (opcode == OP_LUI);
        is_auipc = SUPPORT_AUIPC && (opcode == OP_AUIPC);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_br    = (opcode == OP_BR);
        is_jal   = (opcode == OP_JAL);
        is_jalr  = (opcode == OP_JALR);
        is_legal = |{is_r, is_i, is_lui, is_auipc, is_lw, is_sw, is_br, is_jal, is_jalr};
    end

    // Only unstalled, unacknowledged request cycles count toward the timeout.
    assign wait_cycle = ((state == ST_FETCH) || (state == ST_MEM)) && !stall && !mem_ack;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (state_next != state),
                .count_en (wait_cycle),
                .expire   (expire)
            );
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RESET;
            illegal_instr <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == ST_DECODE) && !stall && !is_legal) illegal_instr <= 1'b1;
            if (expire) timeout_err <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        if (!stall) begin
            unique case (state)
                ST_RESET:  state_next = ST_FETCH;
                ST_FETCH: begin
                    if (mem_ack)     state_next = ST_DECODE;
                    else if (expire) state_next = ST_TRAP;
                end
                ST_DECODE: state_next = is_legal ? ST_EXEC : ST_TRAP;
                ST_EXEC: begin
                    if (is_lw || is_sw) state_next = ST_MEM;
                    else if (is_br)     state_next = ST_FETCH;
                    else                state_next = ST_WB;
                end
                ST_MEM: begin
                    if (mem_ack)     state_next = is_sw ? ST_FETCH : ST_WB;
                    else if (expire) state_next = ST_TRAP;
                end
                ST_WB:     state_next = ST_FETCH;
                ST_TRAP:   state_next = ST_TRAP;
                default:   state_next = ST_RESET;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        alu_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_op     = ALU_ADD;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        rw_sel     = RW_ALU_MEM;
        branch     = 1'b0;
        jalr_sel   = 1'b0;
        unique case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ack;
                pc_write = mem_ack;
            end
            ST_EXEC: begin
                alu_src   = is_lw || is_sw || is_i || is_jalr || is_auipc;
                alu_src_a = is_auipc ? 2'b01 : 2'b00;
                if (is_br)                        alu_op = ALU_BRANCH;
                else if (is_r || is_i || is_jalr) alu_op = ALU_FUNCT;
                else if (is_lui || is_jal)        alu_op = ALU_PASS;
                else                              alu_op = ALU_ADD;
                branch = is_br;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                if (is_jal || is_jalr) rw_sel = RW_PC4;
                else if (is_lui)       rw_sel = RW_IMM;
                else                   rw_sel = RW_ALU_MEM;
                pc_write = is_jal || is_jalr;
                jalr_sel = is_jalr;
            end
            default: ;
        endcase
        // Stall kills every strobe but leaves mux selects at their decoded values.
        if (stall) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            branch    = 1'b0;
        end
    end

    assign state_o = state;

endmodule
